// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter and fetch-request unit for the pipelined core. Holds the
// current PC, picks the next PC (exception > redirect > halt > sequential)
// and offers instruction-memory fetches over a valid/ready handshake.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          back-pressure: no new request is launched while high
//   redirect_valid branch/jump taken this cycle, target on redirect_pc
//   redirect_pc    redirect target
//   exc_valid      exception/trap this cycle, PC goes to EXC_VECTOR
//   halt           request to park the unit in HALT
//   resume         leave HALT
//   req_valid      fetch request valid (registered)
//   req_ready      instruction memory accepts the request
//   req_pc         fetch address (always equal to pc)
//   pc             current PC register
//   pc_seq         pc + INSTR_BYTES, wrapping at 2^ADDR_W
//   halted         high while in HALT (registered)
//   fetch_count    number of accepted requests, wrapping at 2^CNT_W
module pc_fetch_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned INSTR_BYTES  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              exc_valid,
  input  logic              halt,
  input  logic              resume,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VECTOR);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              req_valid_reg, req_valid_next;
  logic              halted_reg, halted_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              accept;

  assign accept = req_valid_reg & req_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        // A halt waits for any offered request to be accepted first;
        // exception and redirect pre-empt it and keep the unit running.
        if (!exc_valid && !redirect_valid && halt &&
            (!req_valid_reg || req_ready)) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (exc_valid) begin
          state_next = ST_RUN;
        end else if (redirect_valid) begin
          // Redirect only retargets the parked PC.
          state_next = ST_HALT;
        end else if (resume) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next        = pc_reg;
    req_valid_next = req_valid_reg;
    count_next     = accept ? count_reg + CNT_W'(1) : count_reg;
    unique case (state_reg)
      ST_BOOT: begin
        req_valid_next = !stall;
      end
      ST_RUN: begin
        if (exc_valid) begin
          // The offered request is withdrawn; one bubble cycle follows.
          pc_next        = EXC_PC;
          req_valid_next = 1'b0;
        end else if (redirect_valid) begin
          pc_next        = redirect_pc;
          req_valid_next = 1'b0;
        end else begin
          if (accept) begin
            pc_next = pc_seq;
          end
          // An unaccepted request holds; otherwise launch a new one when
          // neither back-pressure nor a halt request is present.
          if (!req_valid_reg || accept) begin
            req_valid_next = !stall && !halt;
          end
        end
      end
      ST_HALT: begin
        req_valid_next = 1'b0;
        if (exc_valid) begin
          pc_next = EXC_PC;
        end else if (redirect_valid) begin
          pc_next = redirect_pc;
        end
      end
      default: begin
        pc_next        = RESET_PC;
        req_valid_next = 1'b0;
      end
    endcase
    halted_next = (state_next == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= RESET_PC;
      req_valid_reg <= 1'b0;
      halted_reg    <= 1'b0;
      count_reg     <= '0;
    end else begin
      pc_reg        <= pc_next;
      req_valid_reg <= req_valid_next;
      halted_reg    <= halted_next;
      count_reg     <= count_next;
    end
  end

  assign pc          = pc_reg;
  assign req_pc      = pc_reg;
  assign pc_seq      = pc_reg + PC_STEP;
  assign req_valid   = req_valid_reg;
  assign halted      = halted_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst_n, stall, redirect_valid, exc_valid, halt, resume, req_ready;
  logic [31:0] redirect_pc;
  logic        req_valid, halted;
  logic [31:0] req_pc, pc, pc_seq;
  logic [15:0] fetch_count;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .halt(halt), .resume(resume),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .pc(pc), .pc_seq(pc_seq), .halted(halted), .fetch_count(fetch_count)
  );

  // Narrow instance for wrap-around
  logic       s_rst_n, s_stall, s_ready, s_zero;
  logic [7:0] s_rpc;
  logic       s_req_valid, s_halted;
  logic [7:0] s_req_pc, s_pc, s_pc_seq;
  logic [15:0] s_count;

  pc_fetch_unit #(.ADDR_W(8), .RESET_VECTOR(32'h0000_00FC)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .stall(s_stall),
    .redirect_valid(s_zero), .redirect_pc(s_rpc),
    .exc_valid(s_zero), .halt(s_zero), .resume(s_zero),
    .req_valid(s_req_valid), .req_ready(s_ready), .req_pc(s_req_pc),
    .pc(s_pc), .pc_seq(s_pc_seq), .halted(s_halted), .fetch_count(s_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the three modes of the unit and the rules for each.
  typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [15:0] m_count;

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_count = 16'd0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = m_valid && req_ready;
    if (acc) m_count = m_count + 16'd1;
    case (m_mode)
      M_BOOT: begin
        m_mode  = M_RUN;
        m_valid = !stall;
      end
      M_HALT: begin
        if (exc_valid) begin
          m_pc = 32'h80; m_mode = M_RUN;
        end else if (redirect_valid) begin
          m_pc = redirect_pc;
        end else if (resume) begin
          m_mode = M_RUN;
        end
      end
      default: begin
        if (exc_valid) begin
          m_pc = 32'h80; m_valid = 1'b0;
        end else if (redirect_valid) begin
          m_pc = redirect_pc; m_valid = 1'b0;
        end else begin
          if (acc) m_pc = m_pc + 32'd4;
          if (!m_valid || acc) begin
            if (halt) begin
              m_mode = M_HALT; m_valid = 1'b0;
            end else begin
              m_valid = !stall;
            end
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          stall, halt, resume, redir, exc, ready;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    bit          e_valid, e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[28];

  initial begin
    //            stl  hlt  rsm  rdr  exc  rdy   rpc           exp pc      v     h     cnt
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h0,   1'b1,1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h4,   1'b1,1'b0,16'd1};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h8,   1'b1,1'b0,16'd2};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h8,   1'b1,1'b0,16'd2};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h8,   1'b1,1'b0,16'd2};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h8,   1'b1,1'b0,16'd2};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'hC,   1'b1,1'b0,16'd3};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h10,  1'b1,1'b0,16'd4};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h100, 32'h100, 1'b0,1'b0,16'd4};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h100, 1'b1,1'b0,16'd4};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h104, 1'b1,1'b0,16'd5};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 32'h200, 32'h80,  1'b0,1'b0,16'd6};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h80,  1'b1,1'b0,16'd6};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h80,  1'b1,1'b0,16'd6};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h84,  1'b0,1'b1,16'd7};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h40,  32'h40,  1'b0,1'b1,16'd7};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'h0,   32'h40,  1'b0,1'b0,16'd7};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h40,  1'b1,1'b0,16'd7};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h44,  1'b1,1'b0,16'd8};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h48,  1'b0,1'b1,16'd9};
    tbl[20] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,   32'h80,  1'b0,1'b0,16'd9};
    tbl[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h80,  1'b0,1'b0,16'd9};
    tbl[22] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h80,  1'b0,1'b1,16'd9};
    tbl[23] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,   32'h80,  1'b0,1'b0,16'd9};
    tbl[24] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h80,  1'b1,1'b0,16'd9};
    tbl[25] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h80,  1'b0,1'b0,16'd9};
    tbl[26] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h80,  1'b1,1'b0,16'd9};
    tbl[27] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h84,  1'b1,1'b0,16'd10};

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
    halt = 1'b0; resume = 1'b0; req_ready = 1'b0; redirect_pc = 32'h0;
    s_rst_n = 1'b0; s_stall = 1'b0; s_ready = 1'b0; s_zero = 1'b0; s_rpc = 8'h0;
    model_reset();

    // Reset values while rst_n is low
    #12;
    check("reset pc", pc, 32'h0);
    check("reset req_valid", 32'(req_valid), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset count", 32'(fetch_count), 32'd0);
    check("reset pc_seq", pc_seq, 32'h4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #2;
    check("boot req_valid", 32'(req_valid), 32'd0);

    // Directed vectors
    for (int i = 0; i < 28; i++) begin
      stall = tbl[i].stall; halt = tbl[i].halt; resume = tbl[i].resume;
      redirect_valid = tbl[i].redir; exc_valid = tbl[i].exc;
      req_ready = tbl[i].ready; redirect_pc = tbl[i].rpc;
      tick();
      check($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
      check($sformatf("vec%0d req_pc", i), req_pc, tbl[i].e_pc);
      check($sformatf("vec%0d req_valid", i), 32'(req_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].e_halted));
      check($sformatf("vec%0d count", i), 32'(fetch_count), 32'(tbl[i].e_cnt));
      $display("vec %0d: pc=%h req_valid=%0d halted=%0d count=%0d",
               i, pc, req_valid, halted, fetch_count);
    end

    // Randomized run against the reference model, with one async reset mid-run
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun reset pc", pc, 32'h0);
        check("midrun reset req_valid", 32'(req_valid), 32'd0);
        check("midrun reset count", 32'(fetch_count), 32'd0);
        check("midrun reset halted", 32'(halted), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      stall          = ($urandom_range(99) < 30);
      req_ready      = ($urandom_range(99) < 60);
      exc_valid      = ($urandom_range(99) < 5);
      redirect_valid = ($urandom_range(99) < 10);
      halt           = ($urandom_range(99) < 10);
      resume         = ($urandom_range(99) < 25);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      tick();
      check($sformatf("rnd%0d pc", n), pc, m_pc);
      check($sformatf("rnd%0d req_pc", n), req_pc, m_pc);
      check($sformatf("rnd%0d pc_seq", n), pc_seq, m_pc + 32'd4);
      check($sformatf("rnd%0d req_valid", n), 32'(req_valid), 32'(m_valid));
      check($sformatf("rnd%0d halted", n), 32'(halted), 32'(m_mode == M_HALT));
      check($sformatf("rnd%0d count", n), 32'(fetch_count), 32'(m_count));
      if (req_valid && req_ready)
        $display("rnd %0d: offer pc=%h count=%0d", n, req_pc, fetch_count);
    end
    rst_n = 1'b0;

    // Narrow instance: PC wrap at 2^8 and async reset mid-transfer
    s_ready = 1'b1;
    s_stall = 1'b0;
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    check("small boot pc", 32'(s_pc), 32'hFC);
    check("small boot pc_seq", 32'(s_pc_seq), 32'h00);
    check("small boot req_valid", 32'(s_req_valid), 32'd0);
    @(posedge clk); #1;
    check("small run pc", 32'(s_pc), 32'hFC);
    check("small run req_valid", 32'(s_req_valid), 32'd1);
    $display("small: pc=%h req_valid=%0d count=%0d", s_pc, s_req_valid, s_count);
    @(posedge clk); #1;
    check("small wrap pc", 32'(s_pc), 32'h00);
    check("small wrap req_pc", 32'(s_req_pc), 32'h00);
    check("small wrap count", 32'(s_count), 32'd1);
    $display("small: pc=%h req_valid=%0d count=%0d", s_pc, s_req_valid, s_count);
    @(posedge clk); #1;
    check("small next pc", 32'(s_pc), 32'h04);
    check("small next count", 32'(s_count), 32'd2);
    $display("small: pc=%h req_valid=%0d count=%0d", s_pc, s_req_valid, s_count);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("small async pc", 32'(s_pc), 32'hFC);
    check("small async req_valid", 32'(s_req_valid), 32'd0);
    check("small async count", 32'(s_count), 32'd0);
    check("small async halted", 32'(s_halted), 32'd0);
    @(posedge clk); #1;
    check("small held pc", 32'(s_pc), 32'hFC);
    check("small held req_valid", 32'(s_req_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and fetch-request unit for the pipelined core, and the successor to the single-cycle PC register. It holds the current PC and computes the next PC, with exception, redirect and sequential priority. It issues instruction-memory requests over a valid/ready handshake and supports stall, halt/resume and an accepted-fetch counter. It sits between the branch/exception logic and instruction memory.

Parameters:
ADDR_W, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset (truncated to ADDR_W)
EXC_VECTOR, 32'h0000_0080, PC loaded on exception (truncated to ADDR_W)
INSTR_BYTES, 4, sequential increment per accepted fetch
CNT_W, 16, width of fetch_count

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  downstream back-pressure: no new request launched while high
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_W  target for redirect
exc_valid  input  1  exception/trap this cycle
halt  input  1  request halt
resume  input  1  leave HALT
req_valid  output  1  fetch request valid (registered)
req_ready  input  1  instruction memory accepts request
req_pc  output  ADDR_W  fetch address (equals pc)
pc  output  ADDR_W  current PC register
pc_seq  output  ADDR_W  pc + INSTR_BYTES, modulo 2^ADDR_W
halted  output  1  high while state is HALT
fetch_count  output  CNT_W  number of accepted requests

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VECTOR, req_valid=0, halted=0, fetch_count=0, state=BOOT. All outputs hold these values while rst_n is low, including mid-handshake.
- States: BOOT, RUN, HALT. All outputs are registered except pc_seq and req_pc, which are combinational from pc.
- BOOT: lasts exactly one cycle after reset release, with req_valid=0. Next state is RUN; req_valid becomes 1 on the following edge unless stall is high.
- RUN, with "accept" defined as req_valid & req_ready:
  - On accept: pc <= pc_seq (wraps at 2^ADDR_W), fetch_count++ (wraps), req_valid <= !stall & !halt.
  - req_valid=1 with no accept: req_valid and req_pc hold stable regardless of stall or halt.
  - req_valid=0: req_valid <= !stall & !halt.
- Priority, evaluated every cycle in RUN (highest first): exc_valid > redirect_valid > halt > normal.
  - exc_valid: pc <= EXC_VECTOR, req_valid <= 0 for one bubble cycle. The offered request is withdrawn even if unaccepted; memory tolerates this. If an accept coincides, fetch_count still increments but pc takes EXC_VECTOR.
  - redirect_valid: same as exc_valid but pc <= redirect_pc. If exc_valid and redirect_valid are both high, exc_valid wins and redirect_pc is ignored.
  - halt: pending handshake rule applies. Once req_valid=0, or on the accept edge, go to HALT. pc advances normally on that accept.
- HALT: halted=1, req_valid=0.
  - exc_valid: pc <= EXC_VECTOR, go to RUN.
  - redirect_valid: pc <= redirect_pc, stay in HALT.
  - resume (and no exc): go to RUN; req_valid rises one cycle later unless stall is high.
  - halt and resume both high: resume wins.
- Latency: redirect at edge n gives pc=target at n+1, req_valid=1 at n+2 if stall is low.

Test Plan:
- Reset release, stall=0, req_ready=1 -> BOOT one cycle; req_pc sequence 0x0, 0x4, 0x8, 0xC; fetch_count=4 after 4 accepts.
- req_ready=0 for 3 cycles with req_valid=1 and stall pulsed -> req_pc holds 0x8 and req_valid stays 1; on ready, pc=0xC and fetch_count increments once.
- redirect_valid with redirect_pc=0x100 while the request is unaccepted -> req_valid=0 next cycle, pc=0x100; next cycle req_pc=0x100 valid.
- exc_valid and redirect_valid in the same cycle (redirect_pc=0x200) -> pc=0x80; redirect is ignored.
- halt with an unaccepted request, then ready -> accept completes, halted=1, req_valid=0. Redirect to 0x40 in HALT gives halted=1, pc=0x40. resume gives req_pc=0x40 valid one cycle later.
- ADDR_W=8, RESET_VECTOR=0xFC, ready=1 -> pc wraps 0xFC to 0x00. rst_n low mid-transfer -> immediate pc=0xFC, req_valid=0, fetch_count=0.
